multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle accumulator-CPU controller.
- Sequences FETCH / DECODE / memory-access phases over a shared memory with configurable latency.
- Fully implements LDA, STA, ADD, SUB, JMP, JEZ, LDI and HLT, adding a start/halt lifecycle, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register and the datapath (PC, ACC, ALU, memory address mux).

Parameters:
- OPCODE_W, 3, opcode width; must be >=3; encodings with any bit above [2] set are illegal.
- MEM_LAT, 1, cycles each memory access is held; must be >=1.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution from IDLE or HALT; ignored in all other states.
- opcode  in  OPCODE_W  IR opcode field; valid from DECODE onward.
- acc_zero  in  1  ACC == 0, from the datapath.
- rd_mem  out  1  memory read strobe.
- wr_mem  out  1  memory write strobe.
- addr_sel  out  1  address mux select: 0 = PC, 1 = IR operand.
- ld_ir  out  1  load IR from memory data.
- pc_inc  out  1  PC <= PC+1.
- pc_src  out  1  PC <= IR operand.
- ac_src  out  2  ACC input select: 00 = ALU, 01 = memory, 10 = sign-extended immediate.
- ld_ac  out  1  load ACC.
- alu_add  out  1  ALU add.
- alu_sub  out  1  ALU subtract.
- busy  out  1  state is not IDLE or HALT.
- halted  out  1  state is HALT.
- illegal  out  1  sticky; set on illegal opcode and cleared by rst or start.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- States: IDLE, FETCH, DECODE, MEMRD, MEMWR, HALT.
- State, wait counter (clog2(MEM_LAT+1) bits), illegal and instr_count are registers.
- All strobes are combinational functions of the registered state, wait counter and opcode. No strobe ever depends on start.
- Reset: next edge forces IDLE, wait counter 0, illegal 0, instr_count 0. Every output is 0 in IDLE. Reset mid-operation aborts the instruction; no strobe is asserted in the cycle after reset.
- IDLE: if start, go to FETCH.
- FETCH: rd_mem=1, addr_sel=0 for MEM_LAT cycles. In the last cycle also ld_ir=1 and pc_inc=1, then go to DECODE. Fetch latency is MEM_LAT cycles.
- DECODE: single cycle.
  - LDA/ADD/SUB: go to MEMRD.
  - STA: go to MEMWR.
  - JMP: pc_src=1, go to FETCH.
  - JEZ: pc_src=acc_zero, go to FETCH.
  - LDI: ac_src=10, ld_ac=1, go to FETCH.
  - HLT: go to HALT.
  - Illegal: set illegal, go to HALT; retire count is not incremented.
- MEMRD: rd_mem=1, addr_sel=1 for MEM_LAT cycles. In the last cycle ld_ac=1 with:
  - LDA: ac_src=01.
  - ADD: ac_src=00, alu_add=1.
  - SUB: ac_src=00, alu_sub=1.
  - Then go to FETCH.
- MEMWR: wr_mem=1, addr_sel=1 for MEM_LAT cycles, then go to FETCH.
- Mutual exclusion: pc_inc and pc_src never assert together. rd_mem and wr_mem never assert together.
- Wait counter: cleared on every state entry; increments while in FETCH, MEMRD or MEMWR; the last cycle is count == MEM_LAT-1. With MEM_LAT=1 each memory phase is exactly one cycle.
- Instruction latency:
  - JMP/JEZ/LDI: MEM_LAT+1 cycles.
  - LDA/ADD/SUB/STA: 2*MEM_LAT+1 cycles.
- Retire: instr_count increments once on the final cycle of each legal instruction, including HLT on its DECODE cycle. It saturates at all-ones and does not wrap.
- HALT: halted=1, all strobes 0. If start, clear illegal and go to FETCH; PC is not reset, so execution resumes at PC. instr_count holds across HALT.
- Opcode changes outside DECODE/MEMRD are don't-care. The IR is only loaded in FETCH, so this does not occur in a correct datapath.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants OP_LDA=0 … OP_HLT=7.
  - ac_src constants AC_ALU / AC_MEM / AC_IMM.
  - State enum ctrl_state_t.
- Sub-module saturating_counter (parameter W; inc, clr) for instr_count, reusable for cycle and perf counters elsewhere.
- FSM and output decode stay in this module.

Test Plan:
- Reset then start, opcode=LDA, MEM_LAT=1 → FETCH asserts rd_mem,ld_ir,pc_inc; DECODE; MEMRD asserts rd_mem,addr_sel,ld_ac,ac_src=01; instr_count=1 after 3 cycles.
- MEM_LAT=3, opcode=STA → rd_mem for 3 cycles, then DECODE, then wr_mem+addr_sel for exactly 3 cycles; total 7; rd_mem and wr_mem never overlap.
- JEZ with acc_zero=1 then acc_zero=0 → pc_src=1 in the first DECODE and 0 in the second; pc_inc never coincides with pc_src.
- OPCODE_W=4, opcode=4'b1000 → illegal=1, halted=1, instr_count unchanged; start → illegal=0, FETCH next cycle.
- HLT, then start pulse → halted for ≥1 cycle, then resumes FETCH; instr_count continues from its pre-halt value.
- CNT_W=2, run 5 LDI → instr_count reaches 3 and stays 3. Assert rst during MEMRD → next cycle IDLE, all outputs 0, instr_count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode encodings, ACC source
// selects and the controller state enumeration.
package cpu_pkg;

  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_STA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;
  localparam logic [2:0] OP_JEZ = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  localparam logic [1:0] AC_ALU = 2'b00;
  localparam logic [1:0] AC_MEM = 2'b01;
  localparam logic [1:0] AC_IMM = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEMRD,
    ST_MEMWR,
    ST_HALT
  } ctrl_state_t;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority.
module saturating_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the accumulator CPU: sequences fetch, decode and
// memory phases over a shared memory of latency MEM_LAT and decodes datapath strobes.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int MEM_LAT  = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                acc_zero,
  output logic                rd_mem,
  output logic                wr_mem,
  output logic                addr_sel,
  output logic                ld_ir,
  output logic                pc_inc,
  output logic                pc_src,
  output logic [1:0]          ac_src,
  output logic                ld_ac,
  output logic                alu_add,
  output logic                alu_sub,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  localparam int WAIT_W = $clog2(MEM_LAT + 1);

  ctrl_state_t         state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [OPCODE_W-1:0] hi_bits;
  logic [2:0]          op;
  logic                legal;
  logic                last;
  logic                retire;

  // Any set bit above [2] makes the encoding illegal.
  assign hi_bits = opcode >> 3;
  assign legal   = (hi_bits == '0);
  assign op      = opcode[2:0];
  assign last    = (wait_cnt == WAIT_W'(MEM_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          wait_cnt <= '0;
          if (start) begin
            state   <= ST_FETCH;
            illegal <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (last) begin
            state    <= ST_DECODE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          wait_cnt <= '0;
          if (!legal) begin
            illegal <= 1'b1;
            state   <= ST_HALT;
          end else begin
            case (op)
              OP_LDA, OP_ADD, OP_SUB: state <= ST_MEMRD;
              OP_STA:                 state <= ST_MEMWR;
              OP_HLT:                 state <= ST_HALT;
              default:                state <= ST_FETCH;
            endcase
          end
        end
        ST_MEMRD, ST_MEMWR: begin
          if (last) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rd_mem   = 1'b0;
    wr_mem   = 1'b0;
    addr_sel = 1'b0;
    ld_ir    = 1'b0;
    pc_inc   = 1'b0;
    pc_src   = 1'b0;
    ac_src   = AC_ALU;
    ld_ac    = 1'b0;
    alu_add  = 1'b0;
    alu_sub  = 1'b0;
    retire   = 1'b0;
    case (state)
      ST_FETCH: begin
        rd_mem = 1'b1;
        ld_ir  = last;
        pc_inc = last;
      end
      ST_DECODE: begin
        if (legal) begin
          case (op)
            OP_JMP: begin
              pc_src = 1'b1;
              retire = 1'b1;
            end
            OP_JEZ: begin
              pc_src = acc_zero;
              retire = 1'b1;
            end
            OP_LDI: begin
              ac_src = AC_IMM;
              ld_ac  = 1'b1;
              retire = 1'b1;
            end
            OP_HLT:  retire = 1'b1;
            default: retire = 1'b0;
          endcase
        end
      end
      ST_MEMRD: begin
        rd_mem   = 1'b1;
        addr_sel = 1'b1;
        if (last) begin
          retire = 1'b1;
          case (op)
            OP_LDA: begin
              ac_src = AC_MEM;
              ld_ac  = 1'b1;
            end
            OP_ADD: begin
              ld_ac   = 1'b1;
              alu_add = 1'b1;
            end
            OP_SUB: begin
              ld_ac   = 1'b1;
              alu_sub = 1'b1;
            end
            default: ld_ac = 1'b0;
          endcase
        end
      end
      ST_MEMWR: begin
        wr_mem   = 1'b1;
        addr_sel = 1'b1;
        retire   = last;
      end
      default: retire = 1'b0;
    endcase
  end

  assign busy   = (state != ST_IDLE) && (state != ST_HALT);
  assign halted = (state == ST_HALT);

  saturating_counter #(.W(CNT_W)) u_instr_count (
    .clk   (clk),
    .clr   (rst),
    .inc   (retire),
    .count (instr_count)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two configurations driven cycle by cycle,
// with expected outputs queued per cycle and compared by a negedge monitor.
module tb_multicycle_controller;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Instance A: OPCODE_W=3, MEM_LAT=1, CNT_W=16
  logic        start_a = 1'b0, acc_zero_a = 1'b0;
  logic [2:0]  opcode_a = 3'd0;
  logic        rd_a, wr_a, as_a, ldir_a, pci_a, pcs_a, ldac_a, add_a, sub_a, busy_a, hlt_a, ill_a;
  logic [1:0]  acs_a;
  logic [15:0] cnt_a;

  // Instance B: OPCODE_W=4, MEM_LAT=3, CNT_W=2
  logic        start_b = 1'b0, acc_zero_b = 1'b0;
  logic [3:0]  opcode_b = 4'd0;
  logic        rd_b, wr_b, as_b, ldir_b, pci_b, pcs_b, ldac_b, add_b, sub_b, busy_b, hlt_b, ill_b;
  logic [1:0]  acs_b;
  logic [1:0]  cnt_b;

  multicycle_controller #(.OPCODE_W(3), .MEM_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .opcode(opcode_a), .acc_zero(acc_zero_a),
    .rd_mem(rd_a), .wr_mem(wr_a), .addr_sel(as_a), .ld_ir(ldir_a), .pc_inc(pci_a),
    .pc_src(pcs_a), .ac_src(acs_a), .ld_ac(ldac_a), .alu_add(add_a), .alu_sub(sub_a),
    .busy(busy_a), .halted(hlt_a), .illegal(ill_a), .instr_count(cnt_a)
  );

  multicycle_controller #(.OPCODE_W(4), .MEM_LAT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .opcode(opcode_b), .acc_zero(acc_zero_b),
    .rd_mem(rd_b), .wr_mem(wr_b), .addr_sel(as_b), .ld_ir(ldir_b), .pc_inc(pci_b),
    .pc_src(pcs_b), .ac_src(acs_b), .ld_ac(ldac_b), .alu_add(add_b), .alu_sub(sub_b),
    .busy(busy_b), .halted(hlt_b), .illegal(ill_b), .instr_count(cnt_b)
  );

  // Output vector bit positions: {rd,wr,addr_sel,ld_ir,pc_inc,pc_src,ac_src[1:0],ld_ac,add,sub,busy,halted,illegal}
  localparam logic [13:0] RD  = 14'h2000, WR  = 14'h1000, AS  = 14'h0800, LIR = 14'h0400;
  localparam logic [13:0] PCI = 14'h0200, PCS = 14'h0100, ACI = 14'h0080, ACM = 14'h0040;
  localparam logic [13:0] LAC = 14'h0020, ADD = 14'h0010, SUB = 14'h0008, BSY = 14'h0004;
  localparam logic [13:0] HLD = 14'h0002, ILL = 14'h0001, NONE = 14'h0000;

  localparam logic [13:0] FL   = RD | LIR | PCI | BSY;  // last fetch cycle
  localparam logic [13:0] FW   = RD | BSY;              // earlier fetch cycle
  localparam logic [13:0] DEC  = BSY;
  localparam logic [13:0] MRW  = RD | AS | BSY;
  localparam logic [13:0] MLDA = RD | AS | ACM | LAC | BSY;
  localparam logic [13:0] MADD = RD | AS | LAC | ADD | BSY;
  localparam logic [13:0] MSUB = RD | AS | LAC | SUB | BSY;
  localparam logic [13:0] MW   = WR | AS | BSY;
  localparam logic [13:0] DLDI = ACI | LAC | BSY;

  localparam logic [3:0] LDA = {1'b0, OP_LDA}, STA = {1'b0, OP_STA}, ADDO = {1'b0, OP_ADD};
  localparam logic [3:0] SUBO = {1'b0, OP_SUB}, JMP = {1'b0, OP_JMP}, JEZ = {1'b0, OP_JEZ};
  localparam logic [3:0] LDI = {1'b0, OP_LDI}, HLT = {1'b0, OP_HLT}, BAD = 4'b1000;

  typedef struct packed {
    logic [13:0] sig;
    logic [15:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cyc(input bit which, input logic r, input logic st, input logic [3:0] op,
                     input logic az, input logic [13:0] es, input logic [15:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst   = r;
    e.sig = es;
    e.cnt = ec;
    if (!which) begin
      start_a    = st;
      opcode_a   = op[2:0];
      acc_zero_a = az;
      qa.push_back(e);
    end else begin
      start_b    = st;
      opcode_b   = op;
      acc_zero_b = az;
      qb.push_back(e);
    end
  endtask

  task automatic a(input logic r, input logic st, input logic [3:0] op, input logic az,
                   input logic [13:0] es, input logic [15:0] ec);
    cyc(1'b0, r, st, op, az, es, ec);
  endtask

  task automatic b(input logic r, input logic st, input logic [3:0] op,
                   input logic [13:0] es, input logic [15:0] ec);
    cyc(1'b1, r, st, op, 1'b0, es, ec);
  endtask

  task automatic compare(input string nm, input int idx, input logic [13:0] sig,
                         input logic [15:0] cnt, input exp_t e);
    checks++;
    if (sig !== e.sig) begin
      errors++;
      $display("FAIL %s_outputs cycle %0d: got %b expected %b", nm, idx, sig, e.sig);
    end
    checks++;
    if (cnt !== e.cnt) begin
      errors++;
      $display("FAIL %s_instr_count cycle %0d: got %0d expected %0d", nm, idx, cnt, e.cnt);
    end
  endtask

  int na = 0, nb = 0;

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      compare("a", na, {rd_a, wr_a, as_a, ldir_a, pci_a, pcs_a, acs_a, ldac_a, add_a, sub_a,
                        busy_a, hlt_a, ill_a}, cnt_a, e);
      na++;
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      compare("b", nb, {rd_b, wr_b, as_b, ldir_b, pci_b, pcs_b, acs_b, ldac_b, add_b, sub_b,
                        busy_b, hlt_b, ill_b}, {14'd0, cnt_b}, e);
      nb++;
    end
  end

  initial begin
    // Instance A: reset, LDA, JEZ taken/not taken, ADD, SUB, JMP, LDI, STA, HLT/restart, reset in MEMRD
    a(1, 0, LDA, 0, NONE, 0);
    a(0, 1, LDA, 0, NONE, 0);
    a(0, 0, LDA, 0, FL, 0);
    a(0, 0, LDA, 0, DEC, 0);
    a(0, 0, LDA, 0, MLDA, 0);
    a(0, 0, JEZ, 1, FL, 1);
    a(0, 0, JEZ, 1, DEC | PCS, 1);
    a(0, 0, JEZ, 0, FL, 2);
    a(0, 0, JEZ, 0, DEC, 2);
    a(0, 0, ADDO, 0, FL, 3);
    a(0, 0, ADDO, 0, DEC, 3);
    a(0, 0, ADDO, 0, MADD, 3);
    a(0, 0, SUBO, 0, FL, 4);
    a(0, 0, SUBO, 0, DEC, 4);
    a(0, 0, SUBO, 0, MSUB, 4);
    a(0, 0, JMP, 0, FL, 5);
    a(0, 0, JMP, 0, DEC | PCS, 5);
    a(0, 0, LDI, 0, FL, 6);
    a(0, 0, LDI, 0, DLDI, 6);
    a(0, 0, STA, 0, FL, 7);
    a(0, 0, STA, 0, DEC, 7);
    a(0, 0, STA, 0, MW, 7);
    a(0, 0, HLT, 0, FL, 8);
    a(0, 0, HLT, 0, DEC, 8);
    a(0, 0, HLT, 0, HLD, 9);
    a(0, 1, HLT, 0, HLD, 9);
    a(0, 0, LDI, 0, FL, 9);
    a(0, 0, LDI, 0, DLDI, 9);
    a(0, 0, LDA, 0, FL, 10);
    a(0, 0, LDA, 0, DEC, 10);
    a(1, 0, LDA, 0, MLDA, 10);
    a(0, 0, LDA, 0, NONE, 0);
    a(0, 0, LDA, 0, NONE, 0);

    // Instance B: STA over 3-cycle memory, illegal trap and restart, saturation, reset in MEMRD
    b(0, 1, STA, NONE, 0);
    b(0, 0, STA, FW, 0);
    b(0, 0, STA, FW, 0);
    b(0, 0, STA, FL, 0);
    b(0, 0, STA, DEC, 0);
    b(0, 0, STA, MW, 0);
    b(0, 0, STA, MW, 0);
    b(0, 0, STA, MW, 0);
    b(0, 0, BAD, FW, 1);
    b(0, 0, BAD, FW, 1);
    b(0, 0, BAD, FL, 1);
    b(0, 0, BAD, DEC, 1);
    b(0, 0, BAD, HLD | ILL, 1);
    b(0, 1, BAD, HLD | ILL, 1);
    for (int i = 0; i < 3; i++) begin
      b(0, 0, LDI, FW, 16'(1 + i));
      b(0, 0, LDI, FW, 16'(1 + i));
      b(0, 0, LDI, FL, 16'(1 + i));
      b(0, 0, LDI, DLDI, 16'(1 + i));
    end
    b(0, 0, HLT, FW, 3);
    b(0, 0, HLT, FW, 3);
    b(0, 0, HLT, FL, 3);
    b(0, 0, HLT, DEC, 3);
    b(0, 0, HLT, HLD, 3);
    b(0, 1, HLT, HLD, 3);
    b(0, 0, LDA, FW, 3);
    b(0, 0, LDA, FW, 3);
    b(0, 0, LDA, FL, 3);
    b(0, 0, LDA, DEC, 3);
    b(0, 0, LDA, MRW, 3);
    b(1, 0, LDA, MRW, 3);
    b(0, 0, LDA, NONE, 0);
    b(0, 0, LDA, NONE, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ((qa.size() + qb.size()) != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", qa.size() + qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
